// File: rtl/phase_step_scheduler_if.sv
// Control and gate-drive bundle between the speed/control logic and the
// six-step commutation scheduler.
interface phase_step_scheduler_if #(
    parameter int PERIOD_W = 16
);
    logic                en;
    logic                dir;
    logic [PERIOD_W-1:0] period;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic [2:0]          step;
    logic                step_pulse;
    logic                busy;

    // Control side: supplies run request, direction and step length.
    modport master (
        output en, dir, period,
        input  gate_hi, gate_lo, step, step_pulse, busy
    );

    // Scheduler side: drives the bridge gate enables and status.
    modport slave (
        input  en, dir, period,
        output gate_hi, gate_lo, step, step_pulse, busy
    );
endinterface

// File: rtl/phase_step_scheduler.sv
// Six-step commutation scheduler: per-step tick counter with runtime period,
// forward/reverse stepping and all-off dead-time blanking at every step start.
module phase_step_scheduler #(
    parameter int PERIOD_W    = 16,
    parameter int DEAD_CYCLES = 4     // legal range 1..255
) (
    input logic                   clk,
    input logic                   rst_n,
    phase_step_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_DRIVE
    } state_t;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } gates_t;

    localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] DEAD_LAST = PERIOD_W'(DEAD_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PE_MIN    = PERIOD_W'(DEAD_CYCLES + 1);

    // Bridge pattern per step: one high side and one low side, never the same phase.
    function automatic gates_t step_gates(input logic [2:0] s);
        gates_t g;
        case (s)
            3'd0:    g = '{hi: 3'b001, lo: 3'b010};
            3'd1:    g = '{hi: 3'b001, lo: 3'b100};
            3'd2:    g = '{hi: 3'b010, lo: 3'b100};
            3'd3:    g = '{hi: 3'b010, lo: 3'b001};
            3'd4:    g = '{hi: 3'b100, lo: 3'b001};
            3'd5:    g = '{hi: 3'b100, lo: 3'b010};
            default: g = '0;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] advance(input logic [2:0] s, input logic rev);
        logic [2:0] n;
        if (rev) begin
            n = (s == 3'd0) ? 3'd5 : s - 3'd1;
        end else begin
            n = (s == 3'd5) ? 3'd0 : s + 3'd1;
        end
        return n;
    endfunction

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [PERIOD_W-1:0] last_q, last_d;   // latched Pe-1, the terminal tick
    logic                dir_q, dir_d;
    logic [2:0]          step_q, step_d;
    gates_t              gates_q, gates_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic [PERIOD_W-1:0] last_in;

    // Short or zero periods stretch to one DRIVE cycle after the dead time.
    assign last_in = ((bus.period < PE_MIN) ? PE_MIN : bus.period) - ONE;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        tick_d  = tick_q;
        last_d  = last_q;
        dir_d   = dir_q;
        step_d  = step_q;
        pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (bus.en) begin
                    state_d = S_DEAD;
                    last_d  = last_in;
                    dir_d   = bus.dir;
                end
            end

            S_DEAD, S_DRIVE: begin
                if (!bus.en) begin
                    // Disable wins over a coincident step boundary.
                    state_d = S_IDLE;
                    tick_d  = '0;
                end else if (tick_q == last_q) begin
                    state_d = S_DEAD;
                    tick_d  = '0;
                    step_d  = advance(step_q, dir_q);
                    pulse_d = 1'b1;
                    last_d  = last_in;
                    dir_d   = bus.dir;
                end else begin
                    tick_d = tick_q + ONE;
                    if (state_q == S_DEAD && tick_q == DEAD_LAST) begin
                        state_d = S_DRIVE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase

        // Gate pattern is decided from the next state so outputs come straight from flops.
        gates_d = (state_d == S_DRIVE) ? step_gates(step_d) : '0;
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            last_q  <= PE_MIN - ONE;
            dir_q   <= 1'b0;
            step_q  <= 3'd0;
            gates_q <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            gates_q <= gates_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gate_hi    = gates_q.hi;
    assign bus.gate_lo    = gates_q.lo;
    assign bus.step       = step_q;
    assign bus.step_pulse = pulse_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_phase_step_scheduler.sv
// Scoreboard bench for phase_step_scheduler: a time-based reference model queues
// the expected outputs per edge, a monitor compares them and watches gate safety.
module tb_phase_step_scheduler;

    localparam int PERIOD_W = 16;
    localparam int DEAD     = 4;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
        logic [2:0] step;
        logic       pulse;
        logic       busy;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    phase_step_scheduler_if #(.PERIOD_W(PERIOD_W)) bus ();

    phase_step_scheduler #(
        .PERIOD_W    (PERIOD_W),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    // Reference model: absolute edge number n, start edge of the current step and its length.
    int n      = 0;
    bit m_run  = 1'b0;
    int m_step = 0;
    int m_seg  = 0;
    int m_pe   = DEAD + 1;
    bit m_dir  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int eff_period(input int p);
        return (p > DEAD) ? p : DEAD + 1;
    endfunction

    function automatic bit model_gates_on();
        return m_run && (n - m_seg >= DEAD);
    endfunction

    task automatic model_edge(input bit r_n, input bit e, input bit d, input int p, output obs_t o);
        bit pulse;
        n++;
        pulse = 1'b0;
        if (!r_n) begin
            m_run  = 1'b0;
            m_step = 0;
        end else if (!m_run) begin
            if (e) begin
                m_run = 1'b1;
                m_seg = n;
                m_pe  = eff_period(p);
                m_dir = d;
            end
        end else if (!e) begin
            m_run = 1'b0;
        end else if (n == m_seg + m_pe) begin
            m_step = (m_step + (m_dir ? 5 : 1)) % 6;
            m_seg  = n;
            m_pe   = eff_period(p);
            m_dir  = d;
            pulse  = 1'b1;
        end
        o.step  = 3'(m_step);
        o.pulse = pulse;
        o.busy  = m_run;
        if (model_gates_on()) begin
            // High side walks A,A,B,B,C,C; low side trails it by one step shifted a phase.
            o.hi = 3'(1 << (m_step / 2));
            o.lo = 3'(1 << (((m_step + 1) / 2 + 1) % 3));
        end else begin
            o.hi = 3'b000;
            o.lo = 3'b000;
        end
    endtask

    task automatic apply(input bit r_n, input bit e, input bit d, input int p);
        obs_t o;
        rst_n      = r_n;
        bus.en     = e;
        bus.dir    = d;
        bus.period = PERIOD_W'(p);
        model_edge(r_n, e, d, p, o);
        exp_q.push_back(o);
    endtask

    task automatic drive(input bit r_n, input bit e, input bit d, input int p);
        @(negedge clk);
        apply(r_n, e, d, p);
    endtask

    // Monitor: scoreboard compare plus gate-safety properties on every cycle.
    logic [5:0] prev_g  = '0;
    int         off_run = 0;

    initial begin
        obs_t       cur;
        obs_t       e;
        logic [5:0] g;
        forever begin
            @(posedge clk);
            #1;
            cur = {bus.gate_hi, bus.gate_lo, bus.step, bus.step_pulse, bus.busy};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{hi,lo,step,pulse,busy}", 32'(cur), 32'(e));
            end
            g = {bus.gate_hi, bus.gate_lo};
            check("no_shoot_through", 32'(bus.gate_hi & bus.gate_lo), 32'd0);
            check("step_in_range", 32'(bus.step <= 3'd5), 32'd1);
            if (g != '0 && prev_g == '0) check("dead_time_before_rise", 32'(off_run >= DEAD), 32'd1);
            if (g != '0 && prev_g != '0) check("gates_steady_in_drive", 32'(g), 32'(prev_g));
            off_run = (g == '0) ? off_run + 1 : 0;
            prev_g  = g;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.en     = 1'b0;
        bus.dir    = 1'b0;
        bus.period = '0;

        // Reset held with en high, then idle with en low.
        repeat (5)  drive(1'b0, 1'b1, 1'b0, 10);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 10);

        // Forward run: six full steps and a wrap back to step 0, then stop.
        repeat (63) drive(1'b1, 1'b1, 1'b0, 10);
        drive(1'b1, 1'b0, 1'b0, 10);

        // Reverse from step 0, period change mid-step, dir toggle mid-step.
        repeat (15) drive(1'b1, 1'b1, 1'b1, 10);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 20);
        repeat (10) drive(1'b1, 1'b1, 1'b0, 20);
        repeat (30) drive(1'b1, 1'b1, 1'b0, 20);

        // Clamp: zero and sub-dead periods.
        repeat (20) drive(1'b1, 1'b1, 1'b0, 0);
        repeat (20) drive(1'b1, 1'b1, 1'b0, 3);

        // Disable during DRIVE of step 3, then re-enable.
        guard = 0;
        while (!(m_run && m_step == 3 && (n - m_seg) > DEAD) && guard < 200) begin
            drive(1'b1, 1'b1, 1'b0, 10);
            guard++;
        end
        check("reached_step3_drive", 32'(guard < 200), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 10);
        repeat (3)  drive(1'b1, 1'b0, 1'b0, 10);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 10);

        // Disable exactly on the terminal-count edge.
        guard = 0;
        while (!(m_run && (n + 1) == m_seg + m_pe) && guard < 200) begin
            drive(1'b1, 1'b1, 1'b0, 10);
            guard++;
        end
        check("reached_terminal_count", 32'(guard < 200), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 10);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 10);

        // Asynchronous reset while driving: gates must drop with no clock edge.
        guard = 0;
        while (!model_gates_on() && guard < 200) begin
            drive(1'b1, 1'b1, 1'b1, 12);
            guard++;
        end
        check("reached_drive_before_reset", 32'(guard < 200), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_gates", 32'({bus.gate_hi, bus.gate_lo}), 32'd0);
        check("async_reset_step", 32'(bus.step), 32'd0);
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        apply(1'b0, 1'b1, 1'b1, 12);
        drive(1'b0, 1'b1, 1'b1, 12);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 12);

        // Randomized run with occasional reset pulses.
        for (int i = 0; i < 20000; i++) begin
            bit r_n;
            bit e;
            r_n = !(i == 10000 || $urandom_range(0, 3999) == 0);
            e   = ($urandom_range(0, 99) < 97);
            drive(r_n, e, 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
